// File: rtl/fsm_aspiradora_param.sv
// Vacuum-robot Moore controller with synchronised, debounced switch inputs.
// It also provides a timed evasion manoeuvre, fault escalation after too many
// evasions in one cleaning run, and a low-battery return/charge path.
//
// state     | meaning
// ----------+------------------------------------------------------------
// OFF       | powered down, waiting for the power-up command
// IDLE      | powered, not cleaning
// CLEANING  | cleaning run in progress
// EVADING   | timed obstacle-avoidance manoeuvre
// RETURNING | battery low, heading back to the dock
// CHARGING  | on the dock, charging until the battery recovers
// FAULT     | too many evasions; only power-off or reset leaves it
module fsm_aspiradora_param #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EVADE_CYCLES    = 8,
    parameter int MAX_EVADES      = 5,
    parameter int CNT_W           = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic             i_power_off,
    input  logic             i_on,
    input  logic             i_cleaning,
    input  logic             i_evading,
    input  logic             i_battery_low,
    input  logic             i_docked,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_evade_count,
    output logic             o_fault,
    output logic             o_busy
);

    localparam int NIN   = 6;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W = (EVADE_CYCLES > 1) ? $clog2(EVADE_CYCLES) : 1;

    // Bit positions of the command inputs inside the packed input vectors.
    localparam int IDX_POWER_OFF = 0;
    localparam int IDX_ON        = 1;
    localparam int IDX_CLEANING  = 2;
    localparam int IDX_EVADING   = 3;
    localparam int IDX_BATT_LOW  = 4;
    localparam int IDX_DOCKED    = 5;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(EVADE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FAULT  = CNT_W'(MAX_EVADES);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_IDLE      = 3'd1,
        S_CLEANING  = 3'd2,
        S_EVADING   = 3'd3,
        S_RETURNING = 3'd4,
        S_CHARGING  = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    logic [NIN-1:0]   w_raw;
    logic [NIN-1:0]   r_sync1;
    logic [NIN-1:0]   r_sync2;
    logic [NIN-1:0]   r_deb;
    logic [DB_W-1:0]  r_db_cnt [NIN];

    state_t           r_state;
    state_t           w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_next;
    logic [CNT_W-1:0] r_evade_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_fault;
    logic             r_busy;

    logic w_power_off_d;
    logic w_on_d;
    logic w_cleaning_d;
    logic w_evading_d;
    logic w_battery_low_d;
    logic w_docked_d;

    assign w_raw[IDX_POWER_OFF] = i_power_off;
    assign w_raw[IDX_ON]        = i_on;
    assign w_raw[IDX_CLEANING]  = i_cleaning;
    assign w_raw[IDX_EVADING]   = i_evading;
    assign w_raw[IDX_BATT_LOW]  = i_battery_low;
    assign w_raw[IDX_DOCKED]    = i_docked;

    assign w_power_off_d   = r_deb[IDX_POWER_OFF];
    assign w_on_d          = r_deb[IDX_ON];
    assign w_cleaning_d    = r_deb[IDX_CLEANING];
    assign w_evading_d     = r_deb[IDX_EVADING];
    assign w_battery_low_d = r_deb[IDX_BATT_LOW];
    assign w_docked_d      = r_deb[IDX_DOCKED];

    // Two-flop synchroniser for all asynchronous switch inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else if (i_ena) begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deb <= '0;
            for (int k = 0; k < NIN; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else if (i_ena) begin
            for (int k = 0; k < NIN; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_deb[k]    <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    // Next-state, evasion timer and evasion counter, in command priority order.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_count_next = r_evade_count;

        if (w_power_off_d) begin
            w_state_next = S_OFF;
            w_timer_next = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (w_on_d) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_cleaning_d && !w_battery_low_d) begin
                        w_state_next = S_CLEANING;
                        w_count_next = '0;
                    end else if (w_docked_d && w_battery_low_d) begin
                        w_state_next = S_CHARGING;
                    end
                end
                S_CLEANING: begin
                    if (w_battery_low_d) begin
                        w_state_next = S_RETURNING;
                    end else if (w_evading_d) begin
                        w_state_next = S_EVADING;
                        w_timer_next = TMR_LOAD;
                        if (r_evade_count != CNT_SAT) begin
                            w_count_next = r_evade_count + CNT_W'(1);
                        end
                    end else if (!w_cleaning_d) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_EVADING: begin
                    if (r_evade_count == CNT_FAULT) begin
                        w_state_next = S_FAULT;
                        w_timer_next = '0;
                    end else if (r_timer != '0) begin
                        w_timer_next = r_timer - TMR_W'(1);
                    end else if (w_battery_low_d) begin
                        w_state_next = S_RETURNING;
                    end else if (!w_evading_d) begin
                        w_state_next = S_CLEANING;
                    end
                end
                S_RETURNING: begin
                    if (w_docked_d) begin
                        w_state_next = S_CHARGING;
                    end
                end
                S_CHARGING: begin
                    if (!w_battery_low_d) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_FAULT: begin
                    w_state_next = S_FAULT;
                end
                default: begin
                    w_state_next = S_OFF;
                    w_timer_next = '0;
                end
            endcase
        end
    end

    // State, timer, counter and registered Moore flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_OFF;
            r_timer       <= '0;
            r_evade_count <= '0;
            r_fault       <= 1'b0;
            r_busy        <= 1'b0;
        end else if (i_ena) begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_evade_count <= w_count_next;
            r_fault       <= (w_state_next == S_FAULT);
            r_busy        <= (w_state_next == S_CLEANING) ||
                             (w_state_next == S_EVADING)  ||
                             (w_state_next == S_RETURNING);
        end
    end

    assign o_state       = r_state;
    assign o_evade_count = r_evade_count;
    assign o_fault       = r_fault;
    assign o_busy        = r_busy;

endmodule

// File: doc/fsm_aspiradora_param.md
Name: fsm_aspiradora_param

Overview:
Parametrised successor of the vacuum-robot Moore controller. Adds input synchronisation and debounce, a timed evasion manoeuvre, an evasion counter with fault escalation, and a low-battery return/charge path. Sits directly under the tt_um top wrapper. Takes switch-level commands from ui_in and drives the encoded state plus status flags onto uo_out.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-stable cycles required before a command level is accepted (>=1)
EVADE_CYCLES, 8, minimum cycles spent in EVADING per entry (>=1)
MAX_EVADES, 5, EVADING entries since last IDLE->CLEANING that trigger FAULT (>=1)
CNT_W, 4, width of evade_count (2^CNT_W-1 >= MAX_EVADES)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ena  input  1  clock enable; low freezes state, timers, counters and debounce
power_off  input  1  async switch: power-down command
on  input  1  async switch: power-up command
cleaning  input  1  async switch: start/continue cleaning
evading  input  1  async switch: obstacle detected
battery_low  input  1  async: battery below threshold
docked  input  1  async: robot on dock contacts
state  output  3  encoded Moore state
evade_count  output  CNT_W  EVADING entries in the current cleaning run
fault  output  1  high only in FAULT
busy  output  1  high in CLEANING, EVADING or RETURNING

Behaviour:
- Input path, per input: 2-FF synchroniser, then debounce.
  - Debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive enabled cycles.
  - The counter resets on any glitch back to the current level.
  - Raw change to debounced change = DEBOUNCE_CYCLES+2 edges. The state reacts on the following edge.
- States (encoding): OFF=0, IDLE=1, CLEANING=2, EVADING=3, RETURNING=4, CHARGING=5, FAULT=6. 7 is unused and recovers to OFF on the next edge.
- Transitions use debounced inputs (suffix _d). Evaluated in priority order; the first match wins:
  1. power_off_d: any state -> OFF.
  2. OFF -> IDLE on on_d.
  3. IDLE -> CLEANING on cleaning_d & !battery_low_d. Clears evade_count.
  4. IDLE -> CHARGING on docked_d & battery_low_d.
  5. CLEANING -> RETURNING on battery_low_d.
  6. CLEANING -> EVADING on evading_d. Loads timer = EVADE_CYCLES-1 and increments evade_count (saturating).
  7. CLEANING -> IDLE on !cleaning_d.
  8. EVADING -> FAULT when evade_count == MAX_EVADES.
  9. EVADING: timer decrements each enabled cycle. When timer==0: -> RETURNING if battery_low_d; stay (timer held at 0) if evading_d; else -> CLEANING.
  10. RETURNING -> CHARGING on docked_d.
  11. CHARGING -> IDLE on !battery_low_d.
  12. FAULT is sticky; only power_off_d or rst exits it.
- Minimum EVADING residence is exactly EVADE_CYCLES cycles. battery_low_d during EVADING is honoured only after the timer expires.
- Outputs are Moore, registered, and depend on state/counters only. fault = (state==FAULT). busy is decoded from state.
- Reset (rst=1 at an edge) overrides ena. It sets:
  - state=OFF, evade_count=0, timer=0, fault=0, busy=0
  - synchroniser and debounce registers to 0, debounced levels to 0
- Reset mid-EVADING aborts the manoeuvre with no residual timer.
- Simultaneous commands are resolved by the priority order above. Example: power_off_d and evading_d together -> OFF.
- ena=0: all registers hold. A debounce count in progress is neither advanced nor cleared.

Test Plan:
- Reset then power-up: rst 1 cycle, hold on=1 -> state stays 0 for DEBOUNCE_CYCLES+2 edges (6 at defaults), reads 1 on the 7th edge. fault=0, busy=0.
- Debounce glitch: on=1 for 3 cycles then 0, defaults -> state remains OFF. A 4-cycle-stable pulse after sync is accepted -> IDLE.
- Evasion timing: in CLEANING, evading high 1 cycle past debounce acceptance, then low -> EVADING for exactly 8 cycles, then CLEANING, evade_count=1.
- Fault escalation, MAX_EVADES=2: two evasion entries, second one held -> FAULT (state=6, fault=1). cleaning toggling has no effect. power_off -> OFF.
- Battery path: CLEANING + battery_low -> RETURNING (busy=1). docked -> CHARGING. battery_low released -> IDLE.
- Priority and ena: power_off and evading debounced on the same edge -> OFF. With ena=0 for 10 cycles mid-EVADING, the timer and state are frozen and the manoeuvre resumes with the same remaining count.
